// File: rtl/prng_symbol_arbiter.sv
// prng_symbol_arbiter
// Shares one serial prng_lfsr among NUM_REQ requesters. Requests are granted
// round-robin. The granted symbol width is loaded into the LFSR as its mode,
// the LFSR is enabled, and its valid bits are collected LSB first. The symbol
// is then returned on one tagged response channel.
//
// Ports
//   clock, resetn          : clock and synchronous active-low reset
//   req_valid / req_width  : per-requester strobe and symbol width (slice i = requester i)
//   req_ready              : one-hot accept, combinational, asserted only while idle
//   rsp_valid / rsp_ready  : response handshake
//   rsp_id                 : index of the requester being answered
//   rsp_symbol             : random symbol, zero at and above the width
//   rsp_error              : illegal width or LFSR timeout; symbol is zero when set
//   lfsr_load_mode, lfsr_mode, lfsr_enable : control outputs to prng_lfsr
//   lfsr_valid, lfsr_bit   : serial output from prng_lfsr
module prng_symbol_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int MAXSYMBOLWIDTH = 128,
    parameter int MODE_W         = $clog2(MAXSYMBOLWIDTH) + 1,
    parameter int TIMEOUT        = 1024
) (
    input  logic                         clock,
    input  logic                         resetn,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*MODE_W-1:0]    req_width,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
    output logic [MAXSYMBOLWIDTH-1:0]    rsp_symbol,
    output logic                         rsp_error,
    output logic                         lfsr_load_mode,
    output logic [MODE_W-1:0]            lfsr_mode,
    output logic                         lfsr_enable,
    input  logic                         lfsr_valid,
    input  logic                         lfsr_bit
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAXSYMBOLWIDTH);
    localparam int TO_W  = $clog2(TIMEOUT + 1);
    localparam logic [ID_W:0]     NREQ_L = (ID_W+1)'(NUM_REQ);
    localparam logic [MODE_W-1:0] MAXW_L = MODE_W'(MAXSYMBOLWIDTH);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_RESP} state_t;

    state_t                    r_state;
    logic [ID_W-1:0]           r_rr;
    logic [ID_W-1:0]           r_id;
    logic [MODE_W-1:0]         r_width;
    logic [MODE_W-1:0]         r_cnt;
    logic [TO_W-1:0]           r_tcnt;
    logic [MAXSYMBOLWIDTH-1:0] r_symbol;
    logic                      r_rsp_valid;
    logic                      r_rsp_error;
    logic                      r_load_mode;
    logic [MODE_W-1:0]         r_mode;
    logic                      r_enable;

    logic [ID_W:0]             w_sum  [NUM_REQ];
    logic [ID_W-1:0]           w_cand [NUM_REQ];
    logic [MODE_W-1:0]         w_width_arr [NUM_REQ];
    logic                      w_found;
    logic [ID_W-1:0]           w_grant_idx;
    logic [MODE_W-1:0]         w_sel_width;
    logic                      w_accept;
    logic [ID_W-1:0]           w_rr_next;

    // Candidate k is requester (rr + k) mod NUM_REQ; candidate 0 has priority.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
        assign w_sum[gi]       = {1'b0, r_rr} + (ID_W+1)'(gi);
        assign w_cand[gi]      = (w_sum[gi] >= NREQ_L) ? ID_W'(w_sum[gi] - NREQ_L)
                                                       : ID_W'(w_sum[gi]);
        assign w_width_arr[gi] = req_width[gi*MODE_W +: MODE_W];
    end

    always_comb begin
        w_found     = 1'b0;
        w_grant_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_found && req_valid[w_cand[k]]) begin
                w_found     = 1'b1;
                w_grant_idx = w_cand[k];
            end
        end
    end

    assign w_sel_width = w_width_arr[w_grant_idx];
    assign w_accept    = resetn && (r_state == S_IDLE) && w_found;
    assign req_ready   = w_accept ? (NUM_REQ'(1) << w_grant_idx) : '0;
    assign w_rr_next   = (w_grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_grant_idx + ID_W'(1);

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_rr        <= '0;
            r_id        <= '0;
            r_width     <= '0;
            r_cnt       <= '0;
            r_tcnt      <= '0;
            r_symbol    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_error <= 1'b0;
            r_load_mode <= 1'b0;
            r_mode      <= '0;
            r_enable    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_id    <= w_grant_idx;
                        r_width <= w_sel_width;
                        r_rr    <= w_rr_next;
                        if ((w_sel_width == '0) || (w_sel_width > MAXW_L)) begin
                            // Illegal width: answer immediately, LFSR untouched.
                            r_state     <= S_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_error <= 1'b1;
                            r_symbol    <= '0;
                        end else begin
                            r_state     <= S_LOAD;
                            r_load_mode <= 1'b1;
                            r_mode      <= w_sel_width;
                        end
                    end
                end
                S_LOAD: begin
                    r_load_mode <= 1'b0;
                    r_enable    <= 1'b1;
                    r_cnt       <= '0;
                    r_tcnt      <= '0;
                    r_state     <= S_RUN;
                end
                S_RUN: begin
                    if (lfsr_valid) begin
                        r_symbol[r_cnt[CNT_W-1:0]] <= lfsr_bit;
                        r_tcnt <= '0;
                        if (r_cnt == r_width - MODE_W'(1)) begin
                            r_state     <= S_RESP;
                            r_enable    <= 1'b0;
                            r_rsp_valid <= 1'b1;
                            r_rsp_error <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + MODE_W'(1);
                        end
                    end else if (r_tcnt == TO_W'(TIMEOUT - 1)) begin
                        // This idle cycle is the TIMEOUT-th in a row: abort.
                        r_state     <= S_RESP;
                        r_enable    <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_error <= 1'b1;
                        r_symbol    <= '0;
                    end else begin
                        r_tcnt <= r_tcnt + TO_W'(1);
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_state     <= S_IDLE;
                        r_rsp_valid <= 1'b0;
                        r_rsp_error <= 1'b0;
                        r_symbol    <= '0;
                        r_cnt       <= '0;
                        r_tcnt      <= '0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rsp_valid      = r_rsp_valid;
    assign rsp_id         = r_id;
    assign rsp_symbol     = r_symbol;
    assign rsp_error      = r_rsp_error;
    assign lfsr_load_mode = r_load_mode;
    assign lfsr_mode      = r_mode;
    assign lfsr_enable    = r_enable;

endmodule

// File: tb/tb_prng_symbol_arbiter.sv
// Directed bench for prng_symbol_arbiter (NUM_REQ=4, MAXSYMBOLWIDTH=128,
// TIMEOUT=16). Inputs are driven and outputs sampled on the falling edge.
// Edge n below means the n-th rising edge after a request is accepted.
module tb_prng_symbol_arbiter;

    localparam int NUM_REQ = 4;
    localparam int MAXW    = 128;
    localparam int MODE_W  = 8;
    localparam int TIMEOUT = 16;

    logic                      clock = 1'b0;
    logic                      resetn;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*MODE_W-1:0] req_width;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [1:0]                rsp_id;
    logic [MAXW-1:0]           rsp_symbol;
    logic                      rsp_error;
    logic                      lfsr_load_mode;
    logic [MODE_W-1:0]         lfsr_mode;
    logic                      lfsr_enable;
    logic                      lfsr_valid;
    logic                      lfsr_bit;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    prng_symbol_arbiter #(
        .NUM_REQ(NUM_REQ), .MAXSYMBOLWIDTH(MAXW), .MODE_W(MODE_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clock(clock), .resetn(resetn),
        .req_valid(req_valid), .req_width(req_width), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_symbol(rsp_symbol), .rsp_error(rsp_error),
        .lfsr_load_mode(lfsr_load_mode), .lfsr_mode(lfsr_mode),
        .lfsr_enable(lfsr_enable), .lfsr_valid(lfsr_valid), .lfsr_bit(lfsr_bit)
    );

    task automatic chk(input string tag, input logic [MAXW-1:0] obs, input logic [MAXW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req_ready"}, MAXW'(req_ready), '0);
        chk({tag, "_rsp_valid"}, MAXW'(rsp_valid), '0);
        chk({tag, "_rsp_id"}, MAXW'(rsp_id), '0);
        chk({tag, "_rsp_symbol"}, rsp_symbol, '0);
        chk({tag, "_rsp_error"}, MAXW'(rsp_error), '0);
        chk({tag, "_load_mode"}, MAXW'(lfsr_load_mode), '0);
        chk({tag, "_mode"}, MAXW'(lfsr_mode), '0);
        chk({tag, "_enable"}, MAXW'(lfsr_enable), '0);
    endtask

    initial begin
        logic [15:0]     pat16;
        logic [MAXW-1:0] exp3;
        logic [MAXW-1:0] hold_sym;
        logic [3:0]      exp_oh;
        int              wcnt;

        pat16 = 16'hA5C3;
        exp3  = {64{2'b01}};

        resetn = 1'b0; req_valid = '0; req_width = '0; rsp_ready = 1'b0;
        lfsr_valid = 1'b0; lfsr_bit = 1'b0;
        repeat (2) @(negedge clock);
        chk_all_zero("reset");
        resetn = 1'b1;
        @(negedge clock);
        chk("idle_no_req_ready", MAXW'(req_ready), '0);

        // ---- T1: requester 0, width 16, continuous valid ----
        req_width[0 +: 8] = 8'd16; req_valid = 4'b0001; lfsr_valid = 1'b1;
        #1 chk("t1_grant", MAXW'(req_ready), MAXW'(4'b0001));
        @(negedge clock);                         // after edge 0
        req_valid = '0;
        chk("t1_load_mode", MAXW'(lfsr_load_mode), MAXW'(1));
        chk("t1_mode", MAXW'(lfsr_mode), MAXW'(16));
        chk("t1_enable_low_in_load", MAXW'(lfsr_enable), '0);
        chk("t1_ready_low", MAXW'(req_ready), '0);
        @(negedge clock);                         // after edge 1
        chk("t1_load_mode_drop", MAXW'(lfsr_load_mode), '0);
        chk("t1_mode_held", MAXW'(lfsr_mode), MAXW'(16));
        chk("t1_enable", MAXW'(lfsr_enable), MAXW'(1));
        lfsr_bit = pat16[0];
        for (int k = 1; k < 16; k++) begin
            @(negedge clock);
            lfsr_bit = pat16[k];
        end
        chk("t1_no_rsp_at_17", MAXW'(rsp_valid), '0);
        @(negedge clock);                         // after edge 17
        chk("t1_rsp_valid_at_18", MAXW'(rsp_valid), MAXW'(1));
        chk("t1_rsp_id", MAXW'(rsp_id), '0);
        chk("t1_rsp_symbol", rsp_symbol, MAXW'(pat16));
        chk("t1_rsp_error", MAXW'(rsp_error), '0);
        chk("t1_enable_off_in_resp", MAXW'(lfsr_enable), '0);
        rsp_ready = 1'b1;
        @(negedge clock);
        chk("t1_rsp_valid_drop", MAXW'(rsp_valid), '0);
        rsp_ready = 1'b0;

        // ---- T2: four requesters, width 8, round-robin from 0 ----
        resetn = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        req_width = {4{8'd8}}; req_valid = 4'hF; lfsr_bit = 1'b1; rsp_ready = 1'b1;
        #1;
        for (int n = 0; n < 8; n++) begin
            exp_oh = 4'b0001 << (n % 4);
            wcnt = 0;
            while (req_ready == '0 && wcnt < 40) begin
                @(negedge clock); #1; wcnt++;
            end
            chk("t2_grant", MAXW'(req_ready), MAXW'(exp_oh));
            @(negedge clock);
            wcnt = 0;
            while (!rsp_valid && wcnt < 40) begin
                @(negedge clock); wcnt++;
            end
            chk("t2_rsp_valid", MAXW'(rsp_valid), MAXW'(1));
            chk("t2_rsp_id", MAXW'(rsp_id), MAXW'(n % 4));
            chk("t2_rsp_symbol", rsp_symbol, MAXW'(8'hFF));
            @(negedge clock);
            #1;
        end
        req_valid = '0;
        rsp_ready = 1'b0;

        // ---- T3: requester 1, width 128, response back-pressured ----
        req_width[8 +: 8] = 8'd128; req_valid = 4'b0010;
        #1 chk("t3_grant", MAXW'(req_ready), MAXW'(4'b0010));
        @(negedge clock);                         // after edge 0
        req_valid = 4'b0100; req_width[16 +: 8] = 8'd0;
        chk("t3_mode", MAXW'(lfsr_mode), MAXW'(128));
        @(negedge clock);                         // after edge 1
        lfsr_bit = 1'b1;
        for (int k = 1; k < 128; k++) begin
            @(negedge clock);
            lfsr_bit = (k % 2 == 0);
        end
        @(negedge clock);                         // after edge 129
        chk("t3_rsp_valid", MAXW'(rsp_valid), MAXW'(1));
        chk("t3_rsp_id", MAXW'(rsp_id), MAXW'(1));
        chk("t3_rsp_symbol", rsp_symbol, exp3);
        chk("t3_rsp_error", MAXW'(rsp_error), '0);
        hold_sym = exp3;
        for (int h = 0; h < 10; h++) begin
            @(negedge clock);
            chk("t3_hold_valid", MAXW'(rsp_valid), MAXW'(1));
            chk("t3_hold_id", MAXW'(rsp_id), MAXW'(1));
            chk("t3_hold_symbol", rsp_symbol, hold_sym);
            chk("t3_hold_no_grant", MAXW'(req_ready), '0);
        end
        rsp_ready = 1'b1;
        @(negedge clock);
        chk("t3_rsp_valid_drop", MAXW'(rsp_valid), '0);
        #1 chk("t3_idle_grant", MAXW'(req_ready), MAXW'(4'b0100));

        // ---- T4: requester 2, width 0 then width 129 ----
        @(negedge clock);
        chk("t4a_rsp_valid", MAXW'(rsp_valid), MAXW'(1));
        chk("t4a_rsp_error", MAXW'(rsp_error), MAXW'(1));
        chk("t4a_rsp_symbol", rsp_symbol, '0);
        chk("t4a_rsp_id", MAXW'(rsp_id), MAXW'(2));
        chk("t4a_load_mode", MAXW'(lfsr_load_mode), '0);
        chk("t4a_enable", MAXW'(lfsr_enable), '0);
        req_width[16 +: 8] = 8'd129;
        @(negedge clock);
        #1 chk("t4_regrant", MAXW'(req_ready), MAXW'(4'b0100));
        chk("t4_between_valid", MAXW'(rsp_valid), '0);
        @(negedge clock);
        req_valid = '0;
        chk("t4b_rsp_valid", MAXW'(rsp_valid), MAXW'(1));
        chk("t4b_rsp_error", MAXW'(rsp_error), MAXW'(1));
        chk("t4b_rsp_symbol", rsp_symbol, '0);
        chk("t4b_rsp_id", MAXW'(rsp_id), MAXW'(2));
        chk("t4b_load_mode", MAXW'(lfsr_load_mode), '0);
        chk("t4b_enable", MAXW'(lfsr_enable), '0);
        @(negedge clock);
        chk("t4_rsp_valid_drop", MAXW'(rsp_valid), '0);
        chk("t4_load_mode_quiet", MAXW'(lfsr_load_mode), '0);
        chk("t4_enable_quiet", MAXW'(lfsr_enable), '0);

        // ---- T5: timeout with lfsr_valid stuck low ----
        lfsr_valid = 1'b0;
        req_width[0 +: 8] = 8'd16; req_valid = 4'b0001;
        #1 chk("t5_grant", MAXW'(req_ready), MAXW'(4'b0001));
        @(negedge clock);                         // after edge 0
        req_valid = '0;
        chk("t5_load_mode", MAXW'(lfsr_load_mode), MAXW'(1));
        @(negedge clock);                         // after edge 1
        chk("t5_enable", MAXW'(lfsr_enable), MAXW'(1));
        repeat (15) @(negedge clock);             // after edge 16
        chk("t5_no_rsp_yet", MAXW'(rsp_valid), '0);
        chk("t5_enable_still", MAXW'(lfsr_enable), MAXW'(1));
        @(negedge clock);                         // after edge 17
        chk("t5_rsp_valid", MAXW'(rsp_valid), MAXW'(1));
        chk("t5_rsp_error", MAXW'(rsp_error), MAXW'(1));
        chk("t5_rsp_symbol", rsp_symbol, '0);
        chk("t5_rsp_id", MAXW'(rsp_id), '0);
        chk("t5_enable_drop", MAXW'(lfsr_enable), '0);
        @(negedge clock);
        chk("t5_rsp_valid_drop", MAXW'(rsp_valid), '0);

        // ---- T6: reset in the middle of a width-16 symbol ----
        lfsr_valid = 1'b1; lfsr_bit = 1'b1;
        req_valid = 4'b0001;
        #1 chk("t6_grant", MAXW'(req_ready), MAXW'(4'b0001));
        @(negedge clock);                         // after edge 0
        req_valid = '0;
        @(negedge clock);                         // after edge 1
        repeat (5) @(negedge clock);              // after edge 6: 5 bits captured
        resetn = 1'b0;
        req_valid = 4'b0101; req_width[16 +: 8] = 8'd8;
        @(negedge clock);
        chk_all_zero("t6_reset");
        resetn = 1'b1;
        #1 chk("t6_fresh_grant_req0", MAXW'(req_ready), MAXW'(4'b0001));
        @(negedge clock);
        req_valid = '0;
        chk("t6_load_mode", MAXW'(lfsr_load_mode), MAXW'(1));
        chk("t6_mode", MAXW'(lfsr_mode), MAXW'(16));
        chk("t6_rsp_id", MAXW'(rsp_id), '0);
        chk("t6_no_rsp", MAXW'(rsp_valid), '0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/prng_symbol_arbiter.md
Name: prng_symbol_arbiter

Overview:
- Shares one serial prng_lfsr instance among NUM_REQ requesters.
- Each requester asks for one pseudo-random symbol of a chosen bit width.
- Grants requesters round-robin, loads the width into the LFSR as its mode, and enables it.
- Deserialises the valid LFSR bits (LSB first) and returns the symbol on a single tagged response channel.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- MAXSYMBOLWIDTH, 128, largest legal symbol width; must match the prng_lfsr instance.
- MODE_W, $clog2(MAXSYMBOLWIDTH)+1, width of mode/width fields.
- TIMEOUT, 1024, max cycles to wait for lfsr_valid after enable before aborting.

Ports:
- clock  in  1  system clock, all logic on posedge.
- resetn  in  1  synchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request strobe; held until accepted.
- req_width  in  NUM_REQ*MODE_W  per-requester symbol width; slice i belongs to requester i.
- req_ready  out  NUM_REQ  one-hot accept; a request transfers when req_valid[i] and req_ready[i] are both high.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  $clog2(NUM_REQ)  index of the requester being answered.
- rsp_symbol  out  MAXSYMBOLWIDTH  random symbol; bits at and above the width are 0.
- rsp_error  out  1  illegal width or timeout; rsp_symbol is 0 when set.
- lfsr_load_mode  out  1  to prng_lfsr load_mode.
- lfsr_mode  out  MODE_W  to prng_lfsr mode.
- lfsr_enable  out  1  to prng_lfsr enable.
- lfsr_valid  in  1  from prng_lfsr valid.
- lfsr_bit  in  1  from prng_lfsr lfsr.

Behaviour:
- Reset (resetn=0 at posedge) applies in any state, including mid-operation:
  - state returns to IDLE; round-robin pointer rr=0.
  - All outputs go to 0: req_ready, rsp_*, lfsr_load_mode, lfsr_mode, lfsr_enable.
  - Bit counter, timeout counter and symbol shift register are cleared.
  - Any in-flight symbol is discarded and no response is produced.
- IDLE
  - req_ready is combinational and asserted only in IDLE.
  - Exactly one bit is set: the first i with req_valid[i]=1, searching from rr upward modulo NUM_REQ.
  - On acceptance: latch id and width; set rr = id+1 mod NUM_REQ.
  - Width 0 or width > MAXSYMBOLWIDTH: go to RESP with rsp_error=1 and no LFSR activity.
  - Legal width: go to LOAD.
- LOAD (1 cycle)
  - lfsr_load_mode=1 and lfsr_mode=width for exactly this cycle; then go to RUN.
  - lfsr_mode holds its last value afterwards; lfsr_load_mode returns to 0.
- RUN
  - lfsr_enable=1 (registered output, high from the first RUN cycle).
  - Each posedge with lfsr_valid=1 writes lfsr_bit into symbol[cnt] and increments cnt (starts at 0).
  - Cycles with lfsr_valid=0 are ignored, and a gap may occur mid-symbol.
  - When a bit is captured with cnt==width-1, go to RESP; lfsr_enable is 0 in the RESP cycle.
  - Timeout counter increments on every RUN cycle with lfsr_valid=0 and clears on lfsr_valid=1.
  - If the timeout counter reaches TIMEOUT: go to RESP with rsp_error=1 and symbol forced to 0.
- RESP
  - rsp_valid=1; rsp_id, rsp_symbol and rsp_error stay stable while rsp_ready=0.
  - On the rsp_valid && rsp_ready cycle go to IDLE. rsp_valid drops next cycle; cnt and symbol clear.
  - No new grant occurs until the state is IDLE, so at most one request is outstanding.
- Latency (legal width W, LFSR valid every cycle from the first enabled cycle):
  - accept at cycle 0, load at cycle 1, first bit captured at cycle 2.
  - rsp_valid first seen at cycle W+2.
- Simultaneous requests: only the round-robin winner is accepted. Losers keep req_valid high and are served in rotating order with no starvation. With all NUM_REQ requesting continuously, each is granted once per NUM_REQ grants.
- Widths are unsigned MODE_W values; width == MAXSYMBOLWIDTH is legal.

Test Plan:
- Single requester 0, width=16, LFSR valid continuous → req_ready[0] pulses once; lfsr_load_mode pulses with lfsr_mode=16; rsp_valid at cycle 18; rsp_id=0; rsp_symbol[15:0] equals the 16 captured lfsr bits LSB-first; bits [127:16]=0; rsp_error=0.
- All 4 requesters with width=8, rsp_ready=1 → grant order 0,1,2,3,0,1…; 8 consecutive responses carry rsp_id 0,1,2,3,0,1,2,3.
- Width=128 with rsp_ready held 0 for 10 cycles after rsp_valid → response fields stable for 10 cycles; no new req_ready; IDLE returns the cycle after rsp_ready=1.
- Requester 2 width=0, then width=129 → each gives rsp_error=1 and rsp_symbol=0; lfsr_load_mode and lfsr_enable never assert.
- TIMEOUT=16, lfsr_valid stuck 0 after load → rsp_error=1 exactly 16 RUN cycles after enable; lfsr_enable drops in the RESP cycle.
- resetn=0 for 1 cycle while cnt=5 of width 16 → next cycle all outputs 0 and state IDLE; no response emitted; a fresh request from requester 0 is then granted first.
